// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the mem_arbiter slice: FSM encoding,
// memory address width and the data/instruction address-region prefixes.
package mem_arbiter_pkg;

    localparam int M_ADDR_W = 18;

    localparam logic [1:0] DATA_PREFIX  = 2'b00;
    localparam logic       INSTR_PREFIX = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DATA     = 2'd3
    } state_e;

    function automatic logic [M_ADDR_W-1:0] instr_addr(input logic [15:0] pa, input logic half);
        return {INSTR_PREFIX, pa, half};
    endfunction

    function automatic logic [M_ADDR_W-1:0] data_addr(input logic [15:0] a);
        return {DATA_PREFIX, a};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// External 16-bit memory port shared by instruction fetch and data access.
// master = arbiter side, slave = SRAM/bus side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic [M_ADDR_W-1:0] m_addr;
    logic [15:0]         m_wdata;
    logic                m_req;
    logic                m_we;
    logic                m_err;
    logic [15:0]         m_rdata;
    logic                m_ack;

    modport master (
        output m_addr, m_wdata, m_req, m_we, m_err,
        input  m_rdata, m_ack
    );

    modport slave (
        input  m_addr, m_wdata, m_req, m_we, m_err,
        output m_rdata, m_ack
    );

endinterface

// File: rtl/mem_timeout.sv
// Watchdog for a pending memory request; only instantiated when
// MEM_ARBITER_TIMEOUT_EN is defined. expire fires in the last allowed cycle.
module mem_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Each transaction (including the hi half of a fetch) gets a fresh budget.
    always_comb begin
        expire = req && !ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d  = cnt_q + CNT_W'(1);
        if (!req || ack || expire) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the 16-bit memory port between 32-bit instruction fetch and CPU
// data access. Optional watchdog abort enabled by MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          prog_addr,
    input  logic [15:0]          addr,
    input  logic [15:0]          wdata,
    input  logic                 ram_read,
    input  logic                 ram_write,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic [15:0]          mem_rdata,
    output logic                 mem_busy,
    output logic                 mem_ready,
    mem_arbiter_if.master        bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_e              state_q, state_d;
    logic [15:0]         fa_q, fa_d;
    logic                fv_q, fv_d;
    logic [15:0]         tgt_q, tgt_d;
    logic [31:0]         ibuf_q, ibuf_d;
    logic                ddone_q, ddone_d;
    logic [15:0]         mem_rdata_q, mem_rdata_d;
    logic                mem_ready_q, mem_ready_d;
    logic                m_req_q, m_req_d;
    logic                m_we_q, m_we_d;
    logic [M_ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [15:0]         m_wdata_q, m_wdata_d;
    logic                m_err_q, m_err_d;

    logic strobe, fetch_need, ack, timeout_hit;

`ifdef MEM_ARBITER_TIMEOUT_EN
    mem_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .req    (m_req_q),
        .ack    (bus.m_ack),
        .expire (timeout_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_err_q <= 1'b0;
        else     m_err_q <= m_err_d;
    end
`else
    assign timeout_hit = 1'b0;
    assign m_err_q     = 1'b0;
`endif

    // NOTE: every _d gets a default before the case so no path infers a latch.
    always_comb begin
        strobe     = ram_read | ram_write;
        fetch_need = !fv_q || (fa_q != prog_addr);
        ack        = m_req_q && bus.m_ack;

        state_d     = state_q;
        fa_d        = fa_q;
        fv_d        = fv_q;
        tgt_d       = tgt_q;
        ibuf_d      = ibuf_q;
        ddone_d     = ddone_q && strobe;
        mem_rdata_d = mem_rdata_q;
        mem_ready_d = 1'b0;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_err_d     = m_err_q;

        case (state_q)
            IDLE: begin
                if (strobe && !ddone_q) begin
                    state_d   = DATA;
                    m_req_d   = 1'b1;
                    m_we_d    = ram_write;
                    m_addr_d  = data_addr(addr);
                    m_wdata_d = wdata;
                end else if (fetch_need) begin
                    // fv drops so a half-overwritten ibuf is never shown as valid.
                    state_d  = FETCH_LO;
                    tgt_d    = prog_addr;
                    fv_d     = 1'b0;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = instr_addr(prog_addr, 1'b0);
                end
            end
            FETCH_LO: begin
                if (ack) begin
                    ibuf_d[15:0] = bus.m_rdata;
                    state_d      = FETCH_HI;
                    m_addr_d     = instr_addr(tgt_q, 1'b1);
                end
            end
            FETCH_HI: begin
                if (ack) begin
                    ibuf_d[31:16] = bus.m_rdata;
                    fa_d          = tgt_q;
                    fv_d          = 1'b1;
                    state_d       = IDLE;
                    m_req_d       = 1'b0;
                end
            end
            DATA: begin
                if (ack) begin
                    if (!m_we_q) mem_rdata_d = bus.m_rdata;
                    mem_ready_d = 1'b1;
                    ddone_d     = strobe;
                    state_d     = IDLE;
                    m_req_d     = 1'b0;
                    m_we_d      = 1'b0;
                end
            end
        endcase

        // Abort still completes a data access so the CPU is never left waiting.
        if (timeout_hit) begin
            state_d = IDLE;
            m_req_d = 1'b0;
            m_we_d  = 1'b0;
            m_err_d = 1'b1;
            if (state_q == DATA) begin
                mem_ready_d = 1'b1;
                ddone_d     = strobe;
            end else begin
                fv_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; ibuf is a
    // plain register (not a memory array) so resetting it is cheap and required.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fa_q        <= '0;
            fv_q        <= 1'b0;
            tgt_q       <= '0;
            ibuf_q      <= '0;
            ddone_q     <= 1'b0;
            mem_rdata_q <= '0;
            mem_ready_q <= 1'b0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            fa_q        <= fa_d;
            fv_q        <= fv_d;
            tgt_q       <= tgt_d;
            ibuf_q      <= ibuf_d;
            ddone_q     <= ddone_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ready_q <= mem_ready_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
        end
    end

    assign instr_valid = fv_q && (fa_q == prog_addr);
    assign instr       = instr_valid ? ibuf_q : 32'h0;
    assign mem_rdata   = mem_rdata_q;
    assign mem_ready   = mem_ready_q;
    assign mem_busy    = strobe && !ddone_q && !mem_ready_q;

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_err   = m_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple SRAM model (programmable wait
// states, combinational ack). Timeout checks run only with MEM_ARBITER_TIMEOUT_EN.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prog_addr, addr, wdata;
    logic        ram_read, ram_write;
    logic [31:0] instr;
    logic        instr_valid;
    logic [15:0] mem_rdata;
    logic        mem_busy, mem_ready;

    mem_arbiter_if bus ();

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   waits     = 0;
    logic ack_en    = 1'b1;
    int   wcnt      = 0;
    int   data_acks = 0;
    int   base_acks;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_addr   (prog_addr),
        .addr        (addr),
        .wdata       (wdata),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem_rdata   (mem_rdata),
        .mem_busy    (mem_busy),
        .mem_ready   (mem_ready),
        .bus         (bus)
    );

    function automatic logic [15:0] mem_word(input logic [17:0] a);
        case (a)
            18'h20020: return 16'h1234;
            18'h20021: return 16'hABCD;
            18'h20022: return 16'h1111;
            18'h20023: return 16'h2222;
            18'h00042: return 16'h5A5A;
            default:   return ~a[15:0];
        endcase
    endfunction

    assign bus.m_ack   = bus.m_req && ack_en && (wcnt == waits);
    assign bus.m_rdata = mem_word(bus.m_addr);

    always @(posedge clk) begin
        if (!bus.m_req || bus.m_ack) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
        if (bus.m_req && bus.m_ack && bus.m_addr[17:16] == 2'b00) data_acks <= data_acks + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; prog_addr = 16'h0010; addr = '0; wdata = '0;
        ram_read = 1'b0; ram_write = 1'b0;
        tick();
        check("rst_instr", instr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_busy", mem_busy, 1'b0);
        check("rst_ready", mem_ready, 1'b0);
        check("rst_req", bus.m_req, 1'b0);
        check("rst_we", bus.m_we, 1'b0);
        check("rst_addr", bus.m_addr, 18'h0);
        check("rst_wdata", bus.m_wdata, 16'h0);
        check("rst_err", bus.m_err, 1'b0);
        check("rst_rdata", mem_rdata, 16'h0);

        // Zero-wait fetch of 0x0010
        rst = 1'b0;
        tick();
        check("f1_lo_req", bus.m_req, 1'b1);
        check("f1_lo_addr", bus.m_addr, 18'h20020);
        check("f1_lo_valid", instr_valid, 1'b0);
        tick();
        check("f1_hi_addr", bus.m_addr, 18'h20021);
        check("f1_hi_valid", instr_valid, 1'b0);
        tick();
        check("f1_valid", instr_valid, 1'b1);
        check("f1_instr", instr, 32'hABCD1234);
        check("f1_req_low", bus.m_req, 1'b0);

        // Zero-wait load, held strobe must not re-issue
        base_acks = data_acks;
        ram_read = 1'b1; addr = 16'h0042;
        tick();
        check("ld_addr", bus.m_addr, 18'h00042);
        check("ld_we", bus.m_we, 1'b0);
        check("ld_req", bus.m_req, 1'b1);
        check("ld_busy", mem_busy, 1'b1);
        check("ld_ready_early", mem_ready, 1'b0);
        tick();
        check("ld_ready", mem_ready, 1'b1);
        check("ld_rdata", mem_rdata, 16'h5A5A);
        check("ld_busy_done", mem_busy, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("ld_ready_pulse", mem_ready, 1'b0);
        check("ld_no_reissue_req", bus.m_req, 1'b0);
        check("ld_one_ack", data_acks - base_acks, 1);
        check("ld_busy_held", mem_busy, 1'b0);
        ram_read = 1'b0;
        tick();

        // Store with 3 wait states
        waits = 3; ram_write = 1'b1; addr = 16'h0100; wdata = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("st_req", bus.m_req, 1'b1);
            check("st_we", bus.m_we, 1'b1);
            check("st_wdata", bus.m_wdata, 16'hBEEF);
            check("st_addr", bus.m_addr, 18'h00100);
            check("st_busy", mem_busy, 1'b1);
            check("st_ready_early", mem_ready, 1'b0);
        end
        tick();
        check("st_ready", mem_ready, 1'b1);
        check("st_busy_done", mem_busy, 1'b0);
        check("st_req_low", bus.m_req, 1'b0);
        check("st_rdata_kept", mem_rdata, 16'h5A5A);
        ram_write = 1'b0; waits = 0;
        tick();

        // Load arriving during FETCH_LO waits for the fetch pair
        prog_addr = 16'h0011;
        tick();
        check("fd_lo_addr", bus.m_addr, 18'h20022);
        ram_read = 1'b1; addr = 16'h0042;
        #1;
        check("fd_busy", mem_busy, 1'b1);
        tick();
        check("fd_hi_addr", bus.m_addr, 18'h20023);
        tick();
        check("fd_valid", instr_valid, 1'b1);
        check("fd_instr", instr, 32'h22221111);
        check("fd_busy_wait", mem_busy, 1'b1);
        tick();
        check("fd_data_addr", bus.m_addr, 18'h00042);
        check("fd_data_req", bus.m_req, 1'b1);
        tick();
        check("fd_ready", mem_ready, 1'b1);
        ram_read = 1'b0;
        tick();

        // prog_addr changes during FETCH_HI
        prog_addr = 16'h0010;
        tick();
        check("pc_lo_addr", bus.m_addr, 18'h20020);
        tick();
        check("pc_hi_addr", bus.m_addr, 18'h20021);
        prog_addr = 16'h0011;
        #1;
        check("pc_hi_valid", instr_valid, 1'b0);
        tick();
        check("pc_done_valid", instr_valid, 1'b0);
        check("pc_done_instr", instr, 32'h0);
        tick();
        check("pc_re_lo", bus.m_addr, 18'h20022);
        tick();
        check("pc_re_hi", bus.m_addr, 18'h20023);
        tick();
        check("pc_re_valid", instr_valid, 1'b1);
        check("pc_re_instr", instr, 32'h22221111);

        // Async reset in the middle of a stalled fetch
        ack_en = 1'b0; prog_addr = 16'h0012;
        tick();
        check("rm_req", bus.m_req, 1'b1);
        check("rm_addr", bus.m_addr, 18'h20024);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rm_req_drop", bus.m_req, 1'b0);
        check("rm_valid", instr_valid, 1'b0);
        check("rm_rdata", mem_rdata, 16'h0);
        ack_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rm_re_lo", bus.m_addr, 18'h20024);
        tick(); tick();
        check("rm_re_valid", instr_valid, 1'b1);
        check("rm_re_instr", instr, 32'hFFDAFFDB);

`ifdef MEM_ARBITER_TIMEOUT_EN
        // Memory never acks: request aborted after 8 cycles
        ack_en = 1'b0; prog_addr = 16'h0013;
        tick();
        check("to_req", bus.m_req, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        check("to_req_held", bus.m_req, 1'b1);
        check("to_err_early", bus.m_err, 1'b0);
        tick();
        check("to_req_drop", bus.m_req, 1'b0);
        check("to_err", bus.m_err, 1'b1);
        check("to_valid", instr_valid, 1'b0);
        rst = 1'b1;
        #1;
        check("to_err_clr", bus.m_err, 1'b0);
        tick();
        rst = 1'b0; ack_en = 1'b1;
        tick();
`else
        check("err_tied", bus.m_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single 16-bit external memory port between the CPU's 32-bit instruction fetch and its data load/store path. Each instruction is read as two 16-bit words and presented to the CPU with a valid flag. The block sits between the `cpu` top-level memory signals (program address, data address and data, read/write strobes, busy/ready) and the board SRAM/bus slave.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255, cycles without `m_ack` before a transaction is aborted; used only with `MEM_ARBITER_TIMEOUT_EN`.

Ports:
- Clocking and reset: one clock, `clk`; `rst` is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `prog_addr` in 16: CPU instruction word address.
- `addr` in 16: CPU data address.
- `wdata` in 16: CPU store data.
- `ram_read` in 1: CPU load request, level, held until `mem_ready`.
- `ram_write` in 1: CPU store request, level, held until `mem_ready`.
- `instr` out 32: fetched instruction, `{hi,lo}`; 0 when `instr_valid` is low.
- `instr_valid` out 1: `instr` matches current `prog_addr`.
- `mem_rdata` out 16: load data, held until next load completes.
- `mem_busy` out 1: data request pending, not yet completed.
- `mem_ready` out 1: one-cycle pulse, data access done.
- `m_addr` out 18: memory word address. Data uses `{2'b00,addr}`; instruction words use `{1'b1,prog_addr,half}` with half 0=lo, 1=hi.
- `m_wdata` out 16: memory write data.
- `m_req` out 1: transaction request, held until `m_ack`.
- `m_we` out 1: write qualifier.
- `m_rdata` in 16: read data, valid with `m_ack`.
- `m_ack` in 1: transaction complete; may be combinational in the same cycle as `m_req`.
- `m_err` out 1: sticky timeout flag; cleared only by reset. Tied 0 without `MEM_ARBITER_TIMEOUT_EN`.

## Operation
- FSM states: `IDLE`, `FETCH_LO`, `FETCH_HI`, `DATA`.
- Registers:
  - `fa`: fetched address.
  - `fv`: fetch valid.
  - `ibuf[31:0]`.
  - `ddone`: data-complete lock.
- Fetch needed when `!fv || fa != prog_addr`.
- `IDLE`:
  - Go to `DATA` if `(ram_read|ram_write) && !ddone`. Data has priority.
  - Otherwise go to `FETCH_LO` if a fetch is needed.
  - Otherwise stay.
- `FETCH_LO` and `FETCH_HI`:
  - Latch `prog_addr` into a fetch-target register on entry to `FETCH_LO`.
  - On `m_ack` in `FETCH_LO`: `ibuf[15:0]<=m_rdata`, then go to `FETCH_HI`.
  - On `m_ack` in `FETCH_HI`: `ibuf[31:16]<=m_rdata`, `fa<=target`, `fv<=1`, then go to `IDLE`.
  - The pair is atomic: data requests wait until it finishes.
- `DATA`:
  - `m_we=ram_write`; `m_addr` and `m_wdata` come from the CPU inputs, which are stable while requesting.
  - On `m_ack`: pulse `mem_ready` next cycle, capture `mem_rdata` (loads only), set `ddone`, go to `IDLE`.
  - `ram_read` and `ram_write` both high: treat as write.
- `ddone` clears in any cycle where `ram_read|ram_write` is low. This prevents re-issue while the CPU drops its strobe.
- `mem_busy = (ram_read|ram_write) & !ddone & !mem_ready`.
- `instr_valid = fv && fa == prog_addr` (combinational compare).
- `prog_addr` changing mid-fetch: the pair completes with the old target, `instr_valid` stays low, and a refetch starts from `IDLE`.

## Timing
- Reset values: state `IDLE`, `fv=0`, `ddone=0`, `ibuf=0`, `mem_rdata=0`. All outputs 0: `instr`, `instr_valid`, `mem_busy` (while strobes are low), `mem_ready`, `m_req`, `m_we`, `m_addr`, `m_wdata`, `m_err`.
- Reset asserted mid-transaction drops `m_req` immediately (async). No partial instruction is ever marked valid.
- `m_req`, `m_we`, `m_addr` and `m_wdata` are driven from registered state and stay stable until the `m_ack` cycle.
- Back-to-back transactions are allowed. `m_req` may stay high across `FETCH_LO`→`FETCH_HI` with the address changing the cycle after ack.
- Zero-wait memory (ack in the same cycle as req):
  - Fetch: `IDLE` 1 + `LO` 1 + `HI` 1. `instr_valid` rises 3 cycles after `prog_addr` changes.
  - Load/store: strobe seen in `IDLE` cycle T; `DATA` at T+1; `mem_ready` at T+2.
- Each added memory wait cycle adds one cycle per access.

## Configuration
- `MEM_ARBITER_TIMEOUT_EN` defined:
  - A counter runs while `m_req` is high. It reaches `TIMEOUT_CYCLES` without ack → abort.
  - Abort: drop `m_req`, set `m_err`, return to `IDLE`.
  - Fetch abort leaves `fv=0`.
  - Data abort still pulses `mem_ready` so the CPU does not hang; `mem_rdata` is left unchanged.
- Undefined: no counter; waits indefinitely for `m_ack`; `m_err` tied 0.

## Structure
- Shared package `mem_arbiter_pkg`:
  - state enum encoding.
  - `M_ADDR_W=18`.
  - Address-region constants: data prefix `2'b00`, instruction prefix `1'b1`.
- One natural sub-module: `mem_timeout`, the watchdog counter, instantiated only under the macro.

## Test plan
- Reset, then `prog_addr=0x0010`, zero-wait memory returns lo `0x1234`, hi `0xABCD` → `m_addr` `0x20020` then `0x20021`; `instr=0xABCD1234`, `instr_valid=1` after 3 cycles.
- `ram_read` with `addr=0x0042` asserted while idle and fetched; memory returns `0x5A5A` → `m_addr=0x00042`, `m_we=0`, `mem_ready` pulse at T+2, `mem_rdata=0x5A5A`, no second request while `ram_read` stays high.
- `ram_write`, `addr=0x0100`, `wdata=0xBEEF`, 3 wait cycles → `m_we=1`, `m_wdata=0xBEEF` held 4 cycles, `mem_busy` high until the `mem_ready` cycle.
- `ram_read` asserted during `FETCH_LO` → fetch pair completes first, then the `DATA` access; `instr_valid` and `mem_ready` are both eventually seen.
- `prog_addr` changes `0x0010`→`0x0011` during `FETCH_HI` → `instr_valid` stays 0 and a refetch at `0x20022`/`0x20023` follows.
- With `MEM_ARBITER_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, `m_ack` never asserted → `m_req` drops after 8 cycles, `m_err=1`, `instr_valid=0`; async reset clears `m_err`.
